// File: rtl/ysyx_20020207_lsu.sv
// Load/store unit: runs one AXI4-Lite transaction per instruction and returns
// the lane-extracted, extended load result (or a fault) to write-back.
module ysyx_20020207_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mem_ren,
  input  logic                    mem_wen,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [3:0]              wmask,
  input  logic [2:0]              load_ctl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_rdata,
  output logic                    out_fault,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [3:0]              wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  // state | meaning
  // IDLE  | waiting for an instruction, in_ready high
  // RADDR | read address presented on AR
  // RDATA | waiting for read data on R
  // WRITE | AW and W presented, each drops after its own handshake
  // WRESP | waiting for write response on B
  // DONE  | result held for write-back until out_ready
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RADDR = 3'd1;
  localparam logic [2:0] RDATA = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] WRESP = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [2:0]            load_ctl_q, load_ctl_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  fault_q, fault_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic                  ld_half, ld_word, st_half, st_word, misal;
  logic [DATA_WIDTH-1:0] word, load_ext;

  always_comb begin
    ld_half = (load_ctl == 3'b001) || (load_ctl == 3'b101);
    ld_word = (load_ctl == 3'b010);
    st_half = (wmask == 4'b0011);
    st_word = (wmask == 4'b1111);
    misal   = 1'b0;
    if (mem_ren)
      misal = (ld_half && addr[0]) || (ld_word && (addr[1:0] != 2'b00));
    else if (mem_wen)
      misal = (st_half && addr[0]) || (st_word && (addr[1:0] != 2'b00));
  end

  // Unknown load codes pass the shifted word through unchanged.
  always_comb begin
    word = rdata >> {addr_q[1:0], 3'b000};
    case (load_ctl_q)
      3'b000:  load_ext = {{24{word[7]}}, word[7:0]};
      3'b001:  load_ext = {{16{word[15]}}, word[15:0]};
      3'b100:  load_ext = {24'd0, word[7:0]};
      3'b101:  load_ext = {16'd0, word[15:0]};
      default: load_ext = word;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    load_ctl_d = load_ctl_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (state_q)
      IDLE: if (in_valid) begin
        addr_d     = addr;
        wdata_d    = wdata;
        wmask_d    = wmask;
        load_ctl_d = load_ctl;
        rdata_d    = '0;
        fault_d    = misal;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        if (misal || !(mem_ren || mem_wen)) state_d = DONE;
        else if (mem_ren)                   state_d = RADDR;
        else                                state_d = WRITE;
      end
      RADDR: if (arready) state_d = RDATA;
      RDATA: if (rvalid) begin
        rdata_d = load_ext;
        fault_d = (rresp != 2'b00);
        state_d = DONE;
      end
      WRITE: begin
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: if (bvalid) begin
        fault_d = (bresp != 2'b00);
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      load_ctl_q <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      load_ctl_q <= load_ctl_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Address/data buses are forced to zero whenever their valid is low.
  always_comb begin
    in_ready  = (state_q == IDLE);
    arvalid   = (state_q == RADDR);
    rready    = (state_q == RDATA);
    awvalid   = (state_q == WRITE) && !aw_done_q;
    wvalid    = (state_q == WRITE) && !w_done_q;
    bready    = (state_q == WRESP);
    out_valid = (state_q == DONE);
    out_rdata = rdata_q;
    out_fault = fault_q;
    araddr    = arvalid ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    awaddr    = awvalid ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    wdata_o   = wvalid ? (wdata_q << {addr_q[1:0], 3'b000}) : '0;
    wstrb     = wvalid ? (wmask_q << addr_q[1:0]) : 4'b0000;
  end

endmodule
